// File: rtl/sar_result_reader.sv
// sar_result_reader
// Consumer of the SAR controller's result/valid interface. Each rising edge of
// valid_in captures one 8-bit result into a small circular FIFO; a transmit FSM
// drains the FIFO as MSB-first serial frames on sclk/sdo/frame_n.
// Shares clk with sar_control, so no synchronisers are used.
// Optional build macro: BIT04_SWAP_FIX_EN -- when defined, result bits 0 and 4
// are exchanged on capture to undo the pad-level swap on the result mapping.
module sar_result_reader #(
    parameter int DEPTH   = 4,  // FIFO entries, power of two, >= 2
    parameter int CLK_DIV = 4   // clk cycles per serial bit, even, >= 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             result_in,
    input  logic                   valid_in,
    input  logic                   clr_ovf,
    output logic                   sclk,
    output logic                   sdo,
    output logic                   frame_n,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   overflow,
    output logic                   busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int DIV_W = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [2:0]       BIT_LAST = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             r_valid_q;
    logic             r_overflow;

    state_t           r_state;
    logic [7:0]       r_shift;
    logic [2:0]       r_bit_cnt;
    logic [DIV_W-1:0] r_div_cnt;

    logic             r_sclk;
    logic             r_sdo;
    logic             r_frame_n;
    logic             r_busy;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic             w_push;
    logic             w_full;
    logic             w_pop;
    logic             w_accept;
    logic             w_drop;
    logic [7:0]       w_wr_data;

    state_t           w_state_nxt;
    logic [7:0]       w_shift_nxt;
    logic [2:0]       w_bit_nxt;
    logic [DIV_W-1:0] w_div_nxt;

    logic             w_sclk_nxt;
    logic             w_sdo_nxt;
    logic             w_frame_n_nxt;
    logic             w_busy_nxt;

    // Capture: one push per valid high period, on its first cycle.
    assign w_push = valid_in & ~r_valid_q;
    assign w_full = (r_level == LVL_FULL);

    // A full FIFO can still take a push when the head leaves on the same edge;
    // the pop reads the old head before the write lands in that slot.
    assign w_accept = w_push & (~w_full | w_pop);
    assign w_drop   = w_push & w_full & ~w_pop;

`ifdef BIT04_SWAP_FIX_EN
    assign w_wr_data = {result_in[7:5], result_in[0], result_in[3:1], result_in[4]};
`else
    assign w_wr_data = result_in;
`endif

    // FIFO data array write on accepted push
    // NOTE: the data array has no reset; the pointers and level define which
    // entries are valid, so clearing the storage itself would buy nothing.
    always_ff @(posedge clk) begin
        if (rst_n && w_accept) begin
            r_mem[r_wr_ptr] <= w_wr_data;
        end
    end

    // FIFO pointers, level, valid edge register and sticky overflow flag
    // NOTE: every clocked block uses non-blocking assignments so all registers
    // update together from the values they held before the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_valid_q  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_valid_q <= valid_in;

            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end

            case ({w_accept, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase

            // A new drop beats a coincident clear.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Transmit FSM next-state: pop in IDLE, shift 8 bit periods, one gap period
    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_bit_nxt   = r_bit_cnt;
        w_div_nxt   = r_div_cnt;
        w_pop       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (r_level != '0) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = r_mem[r_rd_ptr];
                    w_bit_nxt   = '0;
                    w_div_nxt   = '0;
                    w_state_nxt = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (r_div_cnt == DIV_LAST) begin
                    w_div_nxt   = '0;
                    w_shift_nxt = {r_shift[6:0], 1'b0};
                    w_bit_nxt   = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == BIT_LAST) begin
                        w_state_nxt = ST_GAP;
                    end
                end else begin
                    w_div_nxt = r_div_cnt + DIV_W'(1);
                end
            end

            ST_GAP: begin
                if (r_div_cnt == DIV_LAST) begin
                    w_div_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_div_nxt = r_div_cnt + DIV_W'(1);
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_div_nxt   = '0;
                w_bit_nxt   = '0;
            end
        endcase
    end

    // Output decode from next-state so the registered pins line up with the state
    always_comb begin
        w_frame_n_nxt = (w_state_nxt != ST_SHIFT);
        w_sclk_nxt    = (w_state_nxt == ST_SHIFT) && (w_div_nxt >= DIV_HALF);
        w_sdo_nxt     = (w_state_nxt == ST_SHIFT) && w_shift_nxt[7];
        w_busy_nxt    = (w_state_nxt != ST_IDLE);
    end

    // Transmit FSM state, shift register and counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_div_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_div_cnt <= w_div_nxt;
        end
    end

    // Registered serial pins and status; reset aborts any frame immediately
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sclk    <= 1'b0;
            r_sdo     <= 1'b0;
            r_frame_n <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_sclk    <= w_sclk_nxt;
            r_sdo     <= w_sdo_nxt;
            r_frame_n <= w_frame_n_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    assign sclk       = r_sclk;
    assign sdo        = r_sdo;
    assign frame_n    = r_frame_n;
    assign fifo_level = r_level;
    assign overflow   = r_overflow;
    assign busy       = r_busy;

endmodule

// File: tb/tb_sar_result_reader.sv
// tb_sar_result_reader
// Scoreboard bench: stimulus pushes expected frame values into a queue via a
// frame-level reference model; a negedge monitor decodes serial frames and
// compares them, plus the per-cycle pin levels the model predicts.
module tb_sar_result_reader;

    localparam int DEPTH   = 4;
    localparam int CLK_DIV = 4;
    localparam int LVL_W   = $clog2(DEPTH) + 1;

`ifdef BIT04_SWAP_FIX_EN
    localparam logic [7:0] A5_EXP   = 8'hB4;
    localparam logic [7:0] SWAP_EXP = 8'h10;
`else
    localparam logic [7:0] A5_EXP   = 8'hA5;
    localparam logic [7:0] SWAP_EXP = 8'h01;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [7:0]       result_in = 8'h00;
    logic             valid_in = 1'b0;
    logic             clr_ovf = 1'b0;
    logic             sclk;
    logic             sdo;
    logic             frame_n;
    logic [LVL_W-1:0] fifo_level;
    logic             overflow;
    logic             busy;

    sar_result_reader #(
        .DEPTH   (DEPTH),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .result_in  (result_in),
        .valid_in   (valid_in),
        .clr_ovf    (clr_ovf),
        .sclk       (sclk),
        .sdo        (sdo),
        .frame_n    (frame_n),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] stored_code(input logic [7:0] r);
        logic [7:0] t;
        t = r;
`ifdef BIT04_SWAP_FIX_EN
        t[0] = r[4];
        t[4] = r[0];
`endif
        return t;
    endfunction

    // ------------------------------------------------------------------
    // Reference model: FIFO contents as a queue, transmitter as frame timing.
    // A popped frame occupies the line for 8*CLK_DIV cycles, the gap for
    // CLK_DIV more, and the next pop can come one cycle after that.
    // ------------------------------------------------------------------
    logic [7:0] fifo_q[$];
    logic [7:0] sb_q[$];
    int         cyc         = 0;
    int         frame_start = -1;
    int         frame_end   = 0;
    int         busy_until  = 0;
    int         tx_free     = 0;
    logic [7:0] m_cur       = 8'h00;
    logic       m_valid_q   = 1'b0;
    logic       m_ovf       = 1'b0;
    logic       m_abort     = 1'b0;

    logic             e_frame_n = 1'b1;
    logic             e_sclk    = 1'b0;
    logic             e_sdo     = 1'b0;
    logic             e_busy    = 1'b0;
    logic [LVL_W-1:0] e_level   = '0;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            fifo_q.delete();
            sb_q.delete();
            frame_start = -1;
            frame_end   = 0;
            busy_until  = 0;
            tx_free     = 0;
            m_valid_q   = 1'b0;
            m_ovf       = 1'b0;
            m_abort     = 1'b1;
        end else begin
            if (cyc >= tx_free && fifo_q.size() > 0) begin
                m_cur       = fifo_q.pop_front();
                frame_start = cyc;
                frame_end   = cyc + 8 * CLK_DIV;
                busy_until  = cyc + 9 * CLK_DIV;
                tx_free     = cyc + 9 * CLK_DIV + 1;
            end
            if (valid_in && !m_valid_q) begin
                if (fifo_q.size() < DEPTH) begin
                    fifo_q.push_back(stored_code(result_in));
                    sb_q.push_back(stored_code(result_in));
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (clr_ovf) begin
                m_ovf = 1'b0;
            end
            m_valid_q = valid_in;
        end

        if (frame_start >= 0 && cyc < frame_end) begin
            e_frame_n = 1'b0;
            e_sclk    = ((cyc - frame_start) % CLK_DIV) >= (CLK_DIV / 2);
            e_sdo     = m_cur[7 - (cyc - frame_start) / CLK_DIV];
        end else begin
            e_frame_n = 1'b1;
            e_sclk    = 1'b0;
            e_sdo     = 1'b0;
        end
        e_busy  = (frame_start >= 0) && (cyc < busy_until);
        e_level = LVL_W'(fifo_q.size());
    end

    // ------------------------------------------------------------------
    // Monitor: per-cycle pin check and serial frame decode
    // ------------------------------------------------------------------
    logic       chk_en     = 1'b0;
    logic       mon_in     = 1'b0;
    logic       mon_prev   = 1'b0;
    logic [7:0] mon_bits   = 8'h00;
    int         mon_len    = 0;
    int         mon_nbits  = 0;
    int         frames_seen = 0;
    logic [7:0] last_frame = 8'h00;

    always @(negedge clk) begin
        if (m_abort) begin
            mon_in    = 1'b0;
            mon_len   = 0;
            mon_nbits = 0;
            m_abort   = 1'b0;
        end
        if (chk_en) begin
            check("pins{frame_n,sclk,sdo,busy,ovf,level}",
                  {24'd0, frame_n, sclk, sdo, busy, overflow, fifo_level},
                  {24'd0, e_frame_n, e_sclk, e_sdo, e_busy, m_ovf, e_level});
            if (!frame_n) begin
                if (!mon_in) begin
                    mon_in    = 1'b1;
                    mon_len   = 0;
                    mon_nbits = 0;
                end
                mon_len++;
                if (sclk && !mon_prev) begin
                    mon_bits = {mon_bits[6:0], sdo};
                    mon_nbits++;
                end
            end else if (mon_in) begin
                mon_in = 1'b0;
                frames_seen++;
                last_frame = mon_bits;
                check("frame_len", mon_len, 8 * CLK_DIV);
                check("frame_bits", mon_nbits, 8);
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL frame_unexpected: got 0x%0h, expected no frame", mon_bits);
                end else begin
                    check("frame_data", mon_bits, sb_q.pop_front());
                end
            end
        end
        mon_prev = sclk;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] d, input int width);
        result_in = d;
        valid_in  = 1'b1;
        repeat (width) tick();
        valid_in = 1'b0;
        tick();
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((fifo_q.size() != 0 || cyc <= busy_until + 1) && guard < 3000) begin
            tick();
            guard++;
        end
        tick();
        if (guard >= 3000) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: got busy after %0d cycles, expected idle", guard);
        end
    endtask

    int f0;

    initial begin
        // Reset
        rst_n = 1'b0;
        repeat (3) tick();
        chk_en = 1'b1;
        check("reset_frame_n", frame_n, 1'b1);
        check("reset_level", fifo_level, 0);
        rst_n = 1'b1;
        tick();

        // One long valid period yields exactly one frame
        f0 = frames_seen;
        pulse(8'hA5, 5);
        wait_idle();
        check("single_frame_count", frames_seen - f0, 1);
        check("single_frame_value", last_frame, A5_EXP);
        check("single_level_empty", fifo_level, 0);

        // Bit 0/4 handling on capture
        pulse(8'h01, 1);
        wait_idle();
        check("swap_frame_value", last_frame, SWAP_EXP);

        // Overflow: transmitter busy with a primer, then five quick pulses
        f0 = frames_seen;
        pulse(8'hFF, 1);
        for (int i = 1; i <= 5; i++) pulse(8'(i), 1);
        check("overflow_set", overflow, 1'b1);
        check("overflow_level_full", fifo_level, DEPTH);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("overflow_cleared", overflow, 1'b0);
        wait_idle();
        check("overflow_frame_count", frames_seen - f0, 5);
        check("overflow_last_frame", last_frame, 8'h04);

        // Push coincident with pop while full and idle
        f0 = frames_seen;
        pulse(8'h11, 1);
        for (int i = 0; i < 4; i++) pulse(8'h21 + 8'(i), 1);
        while (cyc + 1 < tx_free) tick();
        result_in = 8'h25;
        valid_in  = 1'b1;
        tick();
        valid_in = 1'b0;
        check("full_pop_push_level", fifo_level, DEPTH);
        check("full_pop_push_ovf", overflow, 1'b0);
        wait_idle();
        check("full_pop_push_frames", frames_seen - f0, 6);
        check("full_pop_push_last", last_frame, 8'h25);

        // clr_ovf coincident with a dropped push: set wins
        pulse(8'h31, 1);
        for (int i = 0; i < 4; i++) pulse(8'h32 + 8'(i), 1);
        pulse(8'h36, 1);
        check("drop_sets_ovf", overflow, 1'b1);
        clr_ovf   = 1'b1;
        result_in = 8'h37;
        valid_in  = 1'b1;
        tick();
        clr_ovf  = 1'b0;
        valid_in = 1'b0;
        check("clr_vs_drop_ovf", overflow, 1'b1);
        tick();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("clr_alone_ovf", overflow, 1'b0);
        wait_idle();

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            int gap;
            pulse(8'($urandom_range(0, 255)), $urandom_range(1, 4));
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 60) : $urandom_range(0, 6);
            for (int g = 0; g < gap; g++) begin
                clr_ovf = ($urandom_range(0, 15) == 0);
                tick();
            end
            clr_ovf = 1'b0;
        end
        wait_idle();

        // Reset during bit 3 of a frame
        pulse(8'h41, 1);
        pulse(8'h42, 1);
        pulse(8'h43, 1);
        while (cyc + 1 < frame_start + 3 * CLK_DIV + 1) tick();
        rst_n = 1'b0;
        tick();
        check("midreset_frame_n", frame_n, 1'b1);
        check("midreset_sclk", sclk, 1'b0);
        check("midreset_sdo", sdo, 1'b0);
        check("midreset_level", fifo_level, 0);
        check("midreset_busy", busy, 1'b0);
        rst_n = 1'b1;
        f0 = frames_seen;
        repeat (60) tick();
        check("midreset_no_frames", frames_seen - f0, 0);

        check("scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
